// File: rtl/tod_alarm_timer.sv
// tod_alarm_timer: prescaled hour/min (and sec with SECONDS_EN) counter plus NUM_ALARMS compare channels.
// Latency: counters, ticks, hits and set_err are registered, with 1 cycle after the tick or set; there is no backpressure, and run=0 freezes time.
module tod_alarm_timer #(
  parameter  int CLK_DIV    = 4,
  parameter  int HOURS      = 24,
  parameter  int NUM_ALARMS = 4,
  localparam int HW         = $clog2(HOURS),
  localparam int AW         = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic                  set_valid,
  input  logic [HW-1:0]         set_hour,
  input  logic [5:0]            set_min,
  output logic                  set_err,
  input  logic                  alarm_wr,
  input  logic [AW-1:0]         alarm_sel,
  input  logic [HW-1:0]         alarm_hour,
  input  logic [5:0]            alarm_min,
  input  logic                  alarm_on,
  input  logic [NUM_ALARMS-1:0] alarm_clr,
  output logic [HW-1:0]         hour,
  output logic [5:0]            min,
  output logic [5:0]            sec,
  output logic [HW+5:0]         time_out,
  output logic                  min_tick,
  output logic                  day_tick,
  output logic [NUM_ALARMS-1:0] alarm_hit,
  output logic [NUM_ALARMS-1:0] alarm_pend
);

  localparam int DW = $clog2(CLK_DIV);

  logic [DW-1:0]         div_cnt;
  logic                  tick;
  logic                  set_ok;
  logic                  min_step;
  logic                  day_wrap;
  logic [HW-1:0]         nxt_hour;
  logic [5:0]            nxt_min;
  logic [NUM_ALARMS-1:0] hit_vec;
  logic [HW-1:0]         alm_hour [NUM_ALARMS];
  logic [5:0]            alm_min  [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] alm_on;

  assign tick     = run && (div_cnt == DW'(CLK_DIV - 1));
  assign set_ok   = set_valid && (int'(set_hour) < HOURS) && (set_min < 6'd60);
  assign time_out = {hour, min};

`ifdef SECONDS_EN
  logic [5:0] sec_q;

  assign min_step = tick && !set_ok && (sec_q == 6'd59);
  assign sec      = sec_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_q <= '0;
    end else if (set_ok) begin
      sec_q <= '0;
    end else if (tick) begin
      sec_q <= (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
    end
  end
`else
  assign min_step = tick && !set_ok;
  assign sec      = '0;
`endif

  always_comb begin
    nxt_hour = hour;
    nxt_min  = min + 6'd1;
    day_wrap = 1'b0;
    if (min == 6'd59) begin
      nxt_min = '0;
      if (hour == HW'(HOURS - 1)) begin
        nxt_hour = '0;
        day_wrap = 1'b1;
      end else begin
        nxt_hour = hour + HW'(1);
      end
    end
  end

  // Compare against the post-step time so the hit lines up with min_tick
  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      hit_vec[i] = min_step && alm_on[i] && (alm_hour[i] == nxt_hour) && (alm_min[i] == nxt_min);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt    <= '0;
      hour       <= '0;
      min        <= '0;
      min_tick   <= 1'b0;
      day_tick   <= 1'b0;
      set_err    <= 1'b0;
      alarm_hit  <= '0;
      alarm_pend <= '0;
    end else begin
      if (set_ok) begin
        hour    <= set_hour;
        min     <= set_min;
        div_cnt <= '0;
      end else if (run) begin
        div_cnt <= tick ? '0 : div_cnt + DW'(1);
        if (min_step) begin
          hour <= nxt_hour;
          min  <= nxt_min;
        end
      end
      min_tick   <= min_step;
      day_tick   <= min_step && day_wrap;
      set_err    <= set_valid && !set_ok;
      alarm_hit  <= hit_vec;
      alarm_pend <= (alarm_pend & ~alarm_clr) | hit_vec;
    end
  end

  // A select value at or beyond NUM_ALARMS matches no channel, so the write is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alm_on <= '0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        alm_hour[i] <= '0;
        alm_min[i]  <= '0;
      end
    end else if (alarm_wr) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        if (alarm_sel == AW'(i)) begin
          alm_hour[i] <= alarm_hour;
          alm_min[i]  <= alarm_min;
          alm_on[i]   <= alarm_on;
        end
      end
    end
  end

endmodule

// File: tb/tb_tod_alarm_timer.sv
// Bench for tod_alarm_timer: minute-count reference model plus directed and random stimulus.
module tb_tod_alarm_timer;

`ifdef SECONDS_EN
  localparam int CLK_DIV = 2;
`else
  localparam int CLK_DIV = 4;
`endif
  localparam int HOURS = 24;
  localparam int NA    = 4;
  localparam int HW    = 5;
  localparam int AW    = 2;

  logic          clk;
  logic          rst_n;
  logic          run;
  logic          set_valid;
  logic [HW-1:0] set_hour;
  logic [5:0]    set_min;
  logic          set_err;
  logic          alarm_wr;
  logic [AW-1:0] alarm_sel;
  logic [HW-1:0] alarm_hour;
  logic [5:0]    alarm_min;
  logic          alarm_on;
  logic [NA-1:0] alarm_clr;
  logic [HW-1:0] hour;
  logic [5:0]    min;
  logic [5:0]    sec;
  logic [HW+5:0] time_out;
  logic          min_tick;
  logic          day_tick;
  logic [NA-1:0] alarm_hit;
  logic [NA-1:0] alarm_pend;

  tod_alarm_timer #(.CLK_DIV(CLK_DIV), .HOURS(HOURS), .NUM_ALARMS(NA)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .set_valid(set_valid), .set_hour(set_hour), .set_min(set_min), .set_err(set_err),
    .alarm_wr(alarm_wr), .alarm_sel(alarm_sel), .alarm_hour(alarm_hour),
    .alarm_min(alarm_min), .alarm_on(alarm_on), .alarm_clr(alarm_clr),
    .hour(hour), .min(min), .sec(sec), .time_out(time_out),
    .min_tick(min_tick), .day_tick(day_tick),
    .alarm_hit(alarm_hit), .alarm_pend(alarm_pend)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: time kept as minutes since midnight, prescaler as a modulo count
  int            m_pre, m_sec, m_tod;
  int            a_hr [NA];
  int            a_mn [NA];
  logic [NA-1:0] a_on, e_hit, e_pend;
  logic          e_min_tick, e_day_tick, e_set_err;
  logic          m_ok, m_step;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_pre = 0; m_sec = 0; m_tod = 0;
        a_on = '0; e_hit = '0; e_pend = '0;
        e_min_tick = 0; e_day_tick = 0; e_set_err = 0;
        for (int i = 0; i < NA; i++) begin
          a_hr[i] = 0;
          a_mn[i] = 0;
        end
      end else begin
        m_ok   = set_valid && (int'(set_hour) < HOURS) && (int'(set_min) < 60);
        m_step = 0;
        if (m_ok) begin
          m_tod = int'(set_hour) * 60 + int'(set_min);
          m_pre = 0;
          m_sec = 0;
        end else if (run) begin
          m_pre = (m_pre + 1) % CLK_DIV;
          if (m_pre == 0) begin
`ifdef SECONDS_EN
            m_sec  = (m_sec + 1) % 60;
            m_step = (m_sec == 0);
`else
            m_step = 1;
`endif
          end
        end
        if (m_step) m_tod = (m_tod + 1) % (HOURS * 60);
        for (int i = 0; i < NA; i++)
          e_hit[i] = m_step && a_on[i] && (a_hr[i] == m_tod / 60) && (a_mn[i] == m_tod % 60);
        e_pend = e_hit | (e_pend & ~alarm_clr);
        if (alarm_wr && int'(alarm_sel) < NA) begin
          a_hr[alarm_sel] = int'(alarm_hour);
          a_mn[alarm_sel] = int'(alarm_min);
          a_on[alarm_sel] = alarm_on;
        end
        e_min_tick = m_step;
        e_day_tick = m_step && (m_tod == 0);
        e_set_err  = set_valid && !m_ok;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("hour", hour, m_tod / 60);
      chk("min", min, m_tod % 60);
`ifdef SECONDS_EN
      chk("sec", sec, m_sec);
`else
      chk("sec", sec, 0);
`endif
      chk("time_out", time_out, ((m_tod / 60) << 6) | (m_tod % 60));
      chk("min_tick", min_tick, e_min_tick);
      chk("day_tick", day_tick, e_day_tick);
      chk("set_err", set_err, e_set_err);
      chk("alarm_hit", alarm_hit, e_hit);
      chk("alarm_pend", alarm_pend, e_pend);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int cnt;
    rst_n = 0; run = 0; set_valid = 0; set_hour = '0; set_min = '0;
    alarm_wr = 0; alarm_sel = '0; alarm_hour = '0; alarm_min = '0; alarm_on = 0; alarm_clr = '0;
    cyc(2);
    chk("rst_hour", hour, 0);
    chk("rst_min", min, 0);
    chk("rst_pend", alarm_pend, 0);
    chk("rst_tick", min_tick, 0);
    rst_n = 1;
    run   = 1;
`ifdef SECONDS_EN
    cnt = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      cnt += int'(min_tick);
      if (i == 117) chk("sec_at_59", sec, 59);
    end
    chk("sec_wrap_sec", sec, 0);
    chk("sec_wrap_min", min, 1);
    chk("sec_wrap_ticks", cnt, 1);
`else
    cnt = 0;
    for (int i = 0; i < 240; i++) begin
      @(negedge clk);
      cnt += int'(min_tick);
    end
    chk("run240_ticks", cnt, 60);
    chk("run240_hour", hour, 1);
    chk("run240_min", min, 0);

    run = 0; set_valid = 1; set_hour = 23; set_min = 59;
    cyc(1);
    set_valid = 0; run = 1; cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cnt += int'(day_tick);
    end
    chk("day_hour", hour, 0);
    chk("day_min", min, 0);
    chk("day_time_out", time_out, 0);
    chk("day_ticks", cnt, 1);

    run = 0; set_valid = 1; set_hour = 24; set_min = 10;
    cyc(1);
    chk("bad_hour_err", set_err, 1);
    chk("bad_hour_keep", hour, 0);
    set_hour = 3; set_min = 60;
    cyc(1);
    chk("bad_min_err", set_err, 1);
    chk("bad_min_keep", min, 0);
    set_valid = 0; run = 1;
    cyc(3);
    set_valid = 1; set_hour = 5; set_min = 30;
    cyc(1);
    chk("set_tick_hour", hour, 5);
    chk("set_tick_min", min, 30);
    chk("set_tick_notick", min_tick, 0);
    set_valid = 0;
    cyc(4);
    chk("after_set_min", min, 31);
    chk("after_set_tick", min_tick, 1);

    run = 0; set_valid = 1; set_hour = 0; set_min = 0;
    cyc(1);
    set_valid = 0; alarm_wr = 1; alarm_sel = 2; alarm_hour = 0; alarm_min = 3; alarm_on = 1;
    cyc(1);
    alarm_sel = 0; alarm_on = 0;
    cyc(1);
    alarm_wr = 0; run = 1;
    cyc(11);
    chk("alm_early", alarm_hit, 0);
    cyc(1);
    chk("alm_hit", alarm_hit, 4'b0100);
    chk("alm_pend", alarm_pend, 4'b0100);
    run = 0;
    cyc(1);
    chk("alm_hit_once", alarm_hit, 0);
    chk("alm_pend_sticky", alarm_pend, 4'b0100);
    alarm_clr = 4'b0100;
    cyc(1);
    chk("alm_clr", alarm_pend, 0);
    alarm_clr = '0; set_valid = 1; set_hour = 0; set_min = 3;
    cyc(1);
    set_valid = 0;
    chk("set_nohit", alarm_hit, 0);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cnt += int'(min_tick);
    end
    chk("frozen_ticks", cnt, 0);
    chk("frozen_min", min, 3);
`endif

    for (int it = 0; it < 3000; it++) begin
      run        = ($urandom_range(0, 9) != 0);
      set_valid  = ($urandom_range(0, 39) == 0);
      set_hour   = HW'($urandom_range(0, 25));
      set_min    = 6'($urandom_range(0, 62));
      alarm_wr   = ($urandom_range(0, 7) == 0);
      alarm_sel  = AW'($urandom_range(0, NA - 1));
      alarm_hour = ($urandom_range(0, 3) != 0) ? HW'(m_tod / 60) : HW'($urandom_range(0, 31));
      alarm_min  = 6'((m_tod % 60 + $urandom_range(1, 3)) % 60);
      alarm_on   = ($urandom_range(0, 3) != 0);
      alarm_clr  = ($urandom_range(0, 7) == 0) ? NA'($urandom_range(0, 15)) : '0;
      @(negedge clk);
      if (it == 1500) begin
        #2 rst_n = 0;
        #1;
        chk("arst_hour", hour, 0);
        chk("arst_min", min, 0);
        chk("arst_pend", alarm_pend, 0);
        chk("arst_hit", alarm_hit, 0);
        @(negedge clk);
        rst_n = 1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tod_alarm_timer.md
Name: tod_alarm_timer

Overview:
Parametrised time-of-day counter for the seating system, replacing the fixed hour/minute timer. A clock prescaler advances minute and hour counters with correct modulo wrap. The time is loadable through a validated set port. NUM_ALARMS independent compare channels each produce a one-cycle hit pulse and a sticky pending flag, which drive seat-reset and schedule events downstream.

Parameters:
CLK_DIV, 4, clk cycles per timebase tick (≥2); tick = 1 minute, or 1 second with SECONDS_EN
HOURS, 24, hours per day; hour counts 0..HOURS-1 (2..32)
NUM_ALARMS, 4, number of alarm compare channels (1..16)
HW (localparam), $clog2(HOURS), hour field width; AW = max(1,$clog2(NUM_ALARMS))

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
run  in  1  1 = prescaler advances; 0 = time frozen, alarms still writable
set_valid  in  1  load set_hour/set_min this cycle
set_hour  in  HW  hour to load
set_min  in  6  minute to load
set_err  out  1  one-cycle pulse: set rejected (out of range)
alarm_wr  in  1  write alarm channel alarm_sel
alarm_sel  in  AW  channel index for write
alarm_hour  in  HW  alarm hour
alarm_min  in  6  alarm minute
alarm_on  in  1  enable bit written with alarm
alarm_clr  in  NUM_ALARMS  per-channel pending clear
hour  out  HW  current hour
min  out  6  current minute
sec  out  6  current second (0 without SECONDS_EN)
time_out  out  HW+6  {hour, min} concatenated
min_tick  out  1  one-cycle pulse on every minute increment
day_tick  out  1  one-cycle pulse on hour wrap HOURS-1 -> 0
alarm_hit  out  NUM_ALARMS  one-cycle pulse per matching channel
alarm_pend  out  NUM_ALARMS  sticky match flags

Behaviour:
- Reset (async, rst_n=0): prescaler, hour, min, sec, all alarm registers, alarm_on bits, alarm_pend, and all pulses = 0.
- Prescaler div_cnt counts 0..CLK_DIV-1 while run=1. At CLK_DIV-1 it wraps to 0 and asserts the internal tick. run=0 holds div_cnt.
- On a minute step: min 0..58 -> +1. min 59 -> 0 and hour +1. hour HOURS-1 with min 59 -> both 0 and day_tick=1.
- min_tick and day_tick are registered: high for the single cycle after the counter update, aligned with the new hour/min values.
- Set: when set_valid=1 and set_hour<HOURS and set_min<60, load hour/min and clear div_cnt and sec. Set wins over a same-cycle tick; that tick is discarded. An out-of-range set changes nothing and set_err=1 next cycle.
- Alarm write: alarm_wr=1 stores hour, min, and on into channel alarm_sel. alarm_sel ≥ NUM_ALARMS is ignored. A write does not change that channel's alarm_pend.
- Match: evaluated only on a minute step (not on a set, not on an alarm write). If channel i has on=1 and its stored time equals the new {hour,min}, then alarm_hit[i]=1 for one cycle (same cycle as min_tick) and alarm_pend[i] is set. Multiple channels may hit together.
- alarm_clr[i]=1 clears alarm_pend[i]. If clear and a new hit occur in the same cycle, the hit wins (pend stays 1).
- time_out = {hour, min}, combinational from the registers.
- Reset asserted mid-count discards the partial prescale. There is no resume.

Optional Feature:
SECONDS_EN — when defined: tick = 1 second; sec counts 0..59 and its 59->0 wrap produces the minute step; set clears sec to 0. When undefined: tick is the minute step directly; sec is tied to 0; no seconds register exists.

Test Plan:
- Reset then run=1 for 4*60 cycles (CLK_DIV=4, no SECONDS_EN) -> min=60 steps = hour 1, min 0; 60 min_tick pulses.
- Set 23:59 then wait 4 cycles -> hour 0, min 0, day_tick pulse once, time_out=0.
- Set hour=24 or min=60 -> set_err pulse, hour/min unchanged; set_valid same cycle as tick -> loaded value, no increment.
- Alarm ch2=00:03 on, ch0=00:03 off, from 00:00 -> at step to 00:03 alarm_hit=4'b0100 for 1 cycle, alarm_pend[2]=1 until alarm_clr[2].
- Set time to 00:03 with ch2 armed -> no hit; run=0 for 100 cycles -> time frozen, no min_tick.
- With SECONDS_EN, CLK_DIV=2: 120 cycles -> sec 0 -> 59 -> 0, min=1, single min_tick.
